div_result_checker: RTL
=======================

# div_result_checker

Self-checking result stage that sits directly downstream of the 8-bit combinational dividers. Each cycle it captures one dividend/divisor pair together with the quotient and remainder a divider produced, and verifies the division identity arithmetically (Q·B + R == A and R < B), so no reference divider is needed. It accumulates checked, skipped and error counts, latches the first failing sample, and reports pass/fail when the operand stream ends. An exhaustive 65536-pair sweep drives it.

## Interface
Parameters:
- W, 8, operand/result width
- CNT_W, 17, counter width (holds 65536)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; clears counters/error latch, enters RUN
- in_valid  in  1  a/b/q/r valid this cycle
- in_last  in  1  marks final sample of stream; qualified by in_valid
- a  in  W  dividend
- b  in  W  divisor
- q  in  W  quotient under test
- r  in  W  remainder under test
- busy  out  1  high in RUN
- done  out  1  high in DONE, held until start or rst
- pass  out  1  done && err_count == 0
- chk_count  out  CNT_W  samples checked (b != 0)
- skip_count  out  CNT_W  samples skipped (b == 0)
- err_count  out  CNT_W  samples failing check
- first_err_valid  out  1  first-error registers hold a failure
- first_err_a, first_err_b, first_err_q, first_err_r  out  W each  operands/results of first failure

## Operation
- FSM states IDLE, RUN, DONE. Reset -> IDLE.
- IDLE --start--> RUN; DONE --start--> RUN; start in RUN ignored.
- On start: all counters, first_err_* and pipeline valid bits cleared at that edge.
- in_valid samples accepted only in RUN; ignored in IDLE/DONE and in the start cycle itself.
- Stage 1 (capture): registers a, b, q, r, in_last, in_valid.
- Stage 2 (check, on stage-1 valid):
  - b == 0: skip_count += 1; no check; never an error.
  - else compute p = q·b (2W bits) + r, zero-extended to 2W+1 bits; fail if p != {0,a} or r >= b.
  - pass -> chk_count += 1; fail -> chk_count += 1 and err_count += 1.
  - First failure while first_err_valid == 0: latch a/b/q/r, set first_err_valid; later failures do not overwrite.
  - If stage-1 last: RUN -> DONE on the same edge.
- All counters saturate at all-ones; no wrap.
- Stage-1 registers keep loading from inputs (gated by RUN); no backpressure, one sample per cycle.

## Timing
- Reset values: busy 0, done 0, pass 0, all counts 0, first_err_valid 0, first_err_a/b/q/r 0, state IDLE.
- Sample presented in cycle n (in_valid=1) -> counters/first_err reflect it from cycle n+2.
- in_last in cycle n -> done=1, busy=0 from cycle n+2; final counts valid same cycle.
- in_valid on cycles following in_last, before DONE (cycle n+1): not accepted (FSM in RUN, but a last already in flight blocks capture).
- rst mid-RUN: next cycle all outputs at reset values; in-flight samples discarded.
- start concurrent with rst: rst wins.
- pass is combinational from done and err_count.

## Test plan
- Start; 4 correct samples 100/7→14 R2, 255/16→15 R15, 0/9→0 R0, 7/200→0 R7, last on 4th -> cycle after last+2: done=1, pass=1, chk_count=4, err_count=0, skip_count=0.
- Samples 100/7→14 R2 then 100/7→14 R3 then 50/5→9 R5, last -> err_count=2, first_err = {a=100,b=7,q=14,r=3}, pass=0.
- Identity-holds-but-invalid-remainder: 10/3 with q=2, r=4, last -> err_count=1 (r >= b caught).
- Divide by zero: 5/0 with q=FF, r=5, then 9/3→3 R0 last -> skip_count=1, chk_count=1, err_count=0, pass=1.
- Start, 2 samples, assert rst in next cycle -> all counters 0, busy=0, done=0; in_valid samples afterward ignored until new start.
- Exhaustive sweep {a,b}=0000..FFFF from a correct divider, in_last at FFFF -> chk_count=65280, skip_count=256, err_count=0, done=1; then start -> counters return to 0 and busy=1.

Source files
------------

// File: rtl/div_result_checker.sv
// Result checker for 8-bit dividers: verifies Q*B + R == A and R < B on a
// two-stage pipeline, accumulates saturating counts and latches the first failure.
module div_result_checker #(
  parameter int W     = 8,
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     q,
  input  logic [W-1:0]     r,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] skip_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [W-1:0]     first_err_a,
  output logic [W-1:0]     first_err_b,
  output logic [W-1:0]     first_err_q,
  output logic [W-1:0]     first_err_r
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             s1_valid_q, s1_last_q;
  logic [W-1:0]     s1_a_q, s1_b_q, s1_q_q, s1_r_q;
  logic [CNT_W-1:0] chk_q, chk_d, skip_q, skip_d, err_q, err_d;
  logic             fev_q, fev_d;
  logic [W-1:0]     fea_q, fea_d, feb_q, feb_d, feq_q, feq_d, fer_q, fer_d;

  logic             start_go, capture, s2_go, fail;
  logic [2*W-1:0]   prod;
  logic [2*W:0]     recon;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign start_go = start && (state_q != RUN);
  // A last sample sitting in stage 1 blocks capture until the FSM reaches DONE.
  assign capture  = in_valid && (state_q == RUN) && !(s1_valid_q && s1_last_q);
  assign s2_go    = s1_valid_q && (state_q == RUN);

  assign prod  = {{W{1'b0}}, s1_q_q} * {{W{1'b0}}, s1_b_q};
  assign recon = {1'b0, prod} + {{(W+1){1'b0}}, s1_r_q};
  assign fail  = (recon != {{(W+1){1'b0}}, s1_a_q}) || (s1_r_q >= s1_b_q);

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    skip_d  = skip_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    feb_d   = feb_q;
    feq_d   = feq_q;
    fer_d   = fer_q;

    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (s1_valid_q && s1_last_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase

    if (start_go) begin
      chk_d  = '0;
      skip_d = '0;
      err_d  = '0;
      fev_d  = 1'b0;
      fea_d  = '0;
      feb_d  = '0;
      feq_d  = '0;
      fer_d  = '0;
    end else if (s2_go) begin
      if (s1_b_q == '0) begin
        skip_d = sat_inc(skip_q);
      end else begin
        chk_d = sat_inc(chk_q);
        if (fail) begin
          err_d = sat_inc(err_q);
          if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = s1_a_q;
            feb_d = s1_b_q;
            feq_d = s1_q_q;
            fer_d = s1_r_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_q_q     <= '0;
      s1_r_q     <= '0;
      chk_q      <= '0;
      skip_q     <= '0;
      err_q      <= '0;
      fev_q      <= 1'b0;
      fea_q      <= '0;
      feb_q      <= '0;
      feq_q      <= '0;
      fer_q      <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= capture;
      s1_last_q  <= capture && in_last;
      if (state_q == RUN) begin
        s1_a_q <= a;
        s1_b_q <= b;
        s1_q_q <= q;
        s1_r_q <= r;
      end
      chk_q  <= chk_d;
      skip_q <= skip_d;
      err_q  <= err_d;
      fev_q  <= fev_d;
      fea_q  <= fea_d;
      feb_q  <= feb_d;
      feq_q  <= feq_d;
      fer_q  <= fer_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = done && (err_q == '0);
  assign chk_count       = chk_q;
  assign skip_count      = skip_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_a     = fea_q;
  assign first_err_b     = feb_q;
  assign first_err_q     = feq_q;
  assign first_err_r     = fer_q;

endmodule
